spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 125 ++++++++++++
 tb/tb_spi_master.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI master, 8-bit MSB-first frames; modes set by cpol/cpha, latched at start.
// Done pulses 16*(dvsr+1) cycles after accept (17*(dvsr+1) when cpha=1); start is ignored while busy.
module spi_master (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  din,
  input  logic [15:0] dvsr,
  input  logic        start,
  input  logic        cpol,
  input  logic        cpha,
  input  logic        miso,
  output logic [7:0]  dout,
  output logic        sclk,
  output logic        mosi,
  output logic        spi_done_tick,
  output logic        ready
);

  typedef enum logic [1:0] {IDLE, CPHA_DLY, P0, P1} state_e;

  state_e      state_q, state_d;
  logic [15:0] c_q, c_d;
  logic [2:0]  n_q, n_d;
  logic [7:0]  so_q, so_d;
  logic [7:0]  si_q, si_d;
  logic [15:0] dvsr_q, dvsr_d;
  logic        cpol_q, cpol_d;
  logic        cpha_q, cpha_d;
  logic        sclk_q, sclk_d;
  logic        pclk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      n_q     <= '0;
      so_q    <= '0;
      si_q    <= '0;
      dvsr_q  <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      sclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      n_q     <= n_d;
      so_q    <= so_d;
      si_q    <= si_d;
      dvsr_q  <= dvsr_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      sclk_q  <= sclk_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    c_d           = c_q;
    n_d           = n_q;
    so_d          = so_q;
    si_d          = si_q;
    dvsr_d        = dvsr_q;
    cpol_d        = cpol_q;
    cpha_d        = cpha_q;
    ready         = 1'b0;
    spi_done_tick = 1'b0;

    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          so_d    = din;
          dvsr_d  = dvsr;
          cpol_d  = cpol;
          cpha_d  = cpha;
          c_d     = '0;
          n_d     = '0;
          state_d = cpha ? CPHA_DLY : P0;
        end
      end
      CPHA_DLY: begin
        if (c_q == dvsr_q) begin
          c_d     = '0;
          state_d = P0;
        end else begin
          c_d = c_q + 16'd1;
        end
      end
      P0: begin
        if (c_q == dvsr_q) begin
          si_d    = {si_q[6:0], miso};
          c_d     = '0;
          state_d = P1;
        end else begin
          c_d = c_q + 16'd1;
        end
      end
      P1: begin
        if (c_q == dvsr_q) begin
          if (n_q == 3'd7) begin
            spi_done_tick = 1'b1;
            state_d       = IDLE;
          end else begin
            so_d    = {so_q[6:0], 1'b0};
            n_d     = n_q + 3'd1;
            c_d     = '0;
            state_d = P0;
          end
        end else begin
          c_d = c_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Idle tracks the live cpol so the line settles before the next frame is started.
  assign pclk   = ((state_q == P1) && !cpha_q) || ((state_q == P0) && cpha_q);
  assign sclk_d = (state_q == IDLE) ? cpol : (pclk ^ cpol_q);

  assign sclk = sclk_q;
  assign mosi = so_q[7];
  assign dout = si_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: mode timing, loopback data, ignored starts, mid-frame changes, reset abort.
module tb_spi_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  din;
  logic [15:0] dvsr;
  logic        start;
  logic        cpol;
  logic        cpha;
  logic        miso;
  logic [7:0]  dout;
  logic        sclk;
  logic        mosi;
  logic        spi_done_tick;
  logic        ready;

  logic        loop_en = 1'b1;
  logic        slave_en = 1'b0;
  logic        slave_bit = 1'b0;
  logic [7:0]  slave_byte = 8'h00;
  int          slave_k = 0;

  int          n_checks = 0;
  int          n_errors = 0;

  int          done_cyc, ticks, rises, toggles;
  logic [7:0]  mbyte;
  logic        rdy_after, rdy_at_done, even8;

  always #5 clk = ~clk;

  spi_master dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .din           (din),
    .dvsr          (dvsr),
    .start         (start),
    .cpol          (cpol),
    .cpha          (cpha),
    .miso          (miso),
    .dout          (dout),
    .sclk          (sclk),
    .mosi          (mosi),
    .spi_done_tick (spi_done_tick),
    .ready         (ready)
  );

  always_comb miso = loop_en ? mosi : slave_bit;

  // Slave shifts out its next bit on the leading (falling) edge in mode 3.
  always @(negedge sclk) begin
    if (slave_en && slave_k < 8) begin
      slave_bit = slave_byte[3'(7 - slave_k)];
      slave_k   = slave_k + 1;
    end
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cycle 0 is the accept cycle; samples are taken on the falling clk edge of each cycle.
  task automatic xfer(input logic [7:0] b, input logic [15:0] dv, input logic cp,
                      input logic ch, input int ncyc, input int repulse_cyc,
                      input int change_cyc, input int rst_cyc);
    int   last_rise;
    logic prev_sclk;
    @(negedge clk);
    cpol = cp;
    cpha = ch;
    dvsr = dv;
    repeat (2) @(negedge clk);
    din         = b;
    start       = 1'b1;
    done_cyc    = -1;
    ticks       = 0;
    rises       = 0;
    toggles     = 0;
    mbyte       = 8'h00;
    rdy_after   = 1'b0;
    rdy_at_done = 1'b1;
    even8       = 1'b1;
    last_rise   = -1;
    prev_sclk   = sclk;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (spi_done_tick) begin
        ticks = ticks + 1;
        if (done_cyc < 0) begin
          done_cyc    = cyc;
          rdy_at_done = ready;
        end
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) rdy_after = ready;
      if (sclk != prev_sclk) toggles = toggles + 1;
      if (sclk && !prev_sclk) begin
        rises = rises + 1;
        mbyte = {mbyte[6:0], mosi};
        if (last_rise >= 0 && cyc - last_rise != 8) even8 = 1'b0;
        last_rise = cyc;
      end
      prev_sclk = sclk;
      if (cyc == repulse_cyc) begin
        start = 1'b1;
        din   = 8'h00;
      end
      if (cyc == change_cyc) begin
        dvsr = 16'd0;
        cpha = ~cpha;
      end
      if (rst_cyc > 0 && cyc == rst_cyc) begin
        check_val("pre_rst_dout_nonzero", int'(dout != 8'h00), 1);
        check_val("pre_rst_sclk", int'(sclk), 1);
        reset_n = 1'b0;
        #1;
        check_val("rst_ready", int'(ready), 1);
        check_val("rst_dout", int'(dout), 0);
        check_val("rst_sclk", int'(sclk), 0);
        check_val("rst_mosi", int'(mosi), 0);
        check_val("rst_done", int'(spi_done_tick), 0);
      end
      if (rst_cyc > 0 && cyc == rst_cyc + 2) reset_n = 1'b1;
      if (rst_cyc > 0 && cyc == rst_cyc + 3) check_val("rst_sclk_follows_cpol", int'(sclk), int'(cp));
    end
  endtask

  initial begin
    reset_n = 1'b0;
    din     = 8'h00;
    dvsr    = 16'd0;
    start   = 1'b0;
    cpol    = 1'b0;
    cpha    = 1'b0;
    #12;
    check_val("reset_ready", int'(ready), 1);
    check_val("reset_done", int'(spi_done_tick), 0);
    check_val("reset_dout", int'(dout), 0);
    check_val("reset_mosi", int'(mosi), 0);
    check_val("reset_sclk", int'(sclk), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Mode 0 loopback, dvsr=3
    loop_en = 1'b1;
    xfer(8'hA5, 16'd3, 1'b0, 1'b0, 70, -1, -1, -1);
    check_val("m0_done_cyc", done_cyc, 64);
    check_val("m0_ticks", ticks, 1);
    check_val("m0_ready_at_done", int'(rdy_at_done), 0);
    check_val("m0_ready_after", int'(rdy_after), 1);
    check_val("m0_rises", rises, 8);
    check_val("m0_rise_spacing", int'(even8), 1);
    check_val("m0_mosi_bits", int'(mbyte), 'hA5);
    check_val("m0_dout", int'(dout), 'hA5);

    // Mode 3 with a slave returning 0xC3, dvsr=1
    @(negedge clk);
    cpol = 1'b1;
    cpha = 1'b1;
    repeat (2) @(negedge clk);
    check_val("m3_sclk_idle", int'(sclk), 1);
    loop_en    = 1'b0;
    slave_byte = 8'hC3;
    slave_k    = 0;
    slave_en   = 1'b1;
    xfer(8'h3C, 16'd1, 1'b1, 1'b1, 40, -1, -1, -1);
    slave_en = 1'b0;
    check_val("m3_done_cyc", done_cyc, 34);
    check_val("m3_ticks", ticks, 1);
    check_val("m3_dout", int'(dout), 'hC3);
    check_val("m3_mosi_bits", int'(mbyte), 'h3C);
    check_val("m3_sclk_idle_after", int'(sclk), 1);

    // dvsr=0, mode 1: sclk toggles every clk
    loop_en = 1'b1;
    xfer(8'hFF, 16'd0, 1'b0, 1'b1, 22, -1, -1, -1);
    check_val("d0_done_cyc", done_cyc, 17);
    check_val("d0_toggles", toggles, 16);
    check_val("d0_rises", rises, 8);
    check_val("d0_dout", int'(dout), 'hFF);
    check_val("d0_ready_after", int'(rdy_after), 1);

    // Start re-pulsed with din=0x00 mid-transfer is ignored
    xfer(8'h81, 16'd3, 1'b0, 1'b0, 75, 10, -1, -1);
    check_val("rp_done_cyc", done_cyc, 64);
    check_val("rp_ticks", ticks, 1);
    check_val("rp_mosi_bits", int'(mbyte), 'h81);
    check_val("rp_dout", int'(dout), 'h81);

    // dvsr and cpha changed mid-transfer leave timing untouched
    xfer(8'h96, 16'd3, 1'b0, 1'b0, 70, -1, 10, -1);
    check_val("mc_done_cyc", done_cyc, 64);
    check_val("mc_ticks", ticks, 1);
    check_val("mc_dout", int'(dout), 'h96);
    check_val("mc_mosi_bits", int'(mbyte), 'h96);

    // Reset pulsed in cycle 20 of a mode 2 transfer aborts it
    xfer(8'hC3, 16'd3, 1'b1, 1'b0, 70, -1, -1, 20);
    check_val("ra_ticks", ticks, 0);
    check_val("ra_ready", int'(ready), 1);
    check_val("ra_dout_cleared", int'(dout), 0);

    // New transfer after reset completes normally
    xfer(8'h5A, 16'd3, 1'b0, 1'b0, 70, -1, -1, -1);
    check_val("ar_done_cyc", done_cyc, 64);
    check_val("ar_ticks", ticks, 1);
    check_val("ar_dout", int'(dout), 'h5A);
    check_val("ar_ready_after", int'(rdy_after), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
